// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encoding, Aluop codes, funct7 codes, stage FSM states.
// The iterative multiplier is present only when ALU_MUL_EN is defined.
package alu_pkg;

    localparam int unsigned ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_MUL  = 4'd10
    } alu_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/alu_decode.sv
// Combinational {Aluop, funct7, funct3} -> ALU op decode with illegal flag.
// The MUL encoding is recognised only when ALU_MUL_EN is defined.
module alu_decode
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output alu_op_t    op_c,
    output logic       illegal_c
);

    // Decode table; anything not matched is flagged illegal.
    always_comb begin
        op_c      = OP_ADD;
        illegal_c = 1'b1;
        case (aluop)
            ALUOP_ADD: begin
                op_c      = OP_ADD;
                illegal_c = 1'b0;
            end
            ALUOP_SUB: begin
                op_c      = OP_SUB;
                illegal_c = 1'b0;
            end
            ALUOP_RTYPE: begin
                illegal_c = 1'b0;
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}:   op_c = OP_ADD;
                    {F7_BASE, 3'b111}:   op_c = OP_AND;
                    {F7_BASE, 3'b110}:   op_c = OP_OR;
                    {F7_BASE, 3'b100}:   op_c = OP_XOR;
                    {F7_BASE, 3'b010}:   op_c = OP_SLT;
                    {F7_BASE, 3'b011}:   op_c = OP_SLTU;
                    {F7_BASE, 3'b001}:   op_c = OP_SLL;
                    {F7_BASE, 3'b101}:   op_c = OP_SRL;
                    {F7_ALT, 3'b000}:    op_c = OP_SUB;
                    {F7_ALT, 3'b101}:    op_c = OP_SRA;
`ifdef ALU_MUL_EN
                    {F7_MULDIV, 3'b000}: op_c = OP_MUL;
`endif
                    default:             illegal_c = 1'b1;
                endcase
            end
            default: begin
                illegal_c = 1'b0;
                case (funct3)
                    3'b000: op_c = OP_ADD;
                    3'b010: op_c = OP_SLT;
                    3'b011: op_c = OP_SLTU;
                    3'b100: op_c = OP_XOR;
                    3'b110: op_c = OP_OR;
                    3'b111: op_c = OP_AND;
                    3'b001: begin
                        op_c      = OP_SLL;
                        illegal_c = (funct7 != F7_BASE);
                    end
                    default: begin
                        if (funct7 == F7_BASE) begin
                            op_c = OP_SRL;
                        end else if (funct7 == F7_ALT) begin
                            op_c = OP_SRA;
                        end else begin
                            illegal_c = 1'b1;
                        end
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// EX-stage ALU: decode + XLEN datapath behind valid/ready, registered result.
// Define ALU_MUL_EN to add the iterative shift-add multiplier (XLEN cycles per MUL).
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      Aluop,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            out_illegal
);

    alu_op_t         dec_op;
    logic            dec_illegal;
    logic            accept_c;
    logic            load_c;
    logic            load_illegal_c;
    logic [XLEN-1:0] alu_result_c;
    logic [XLEN-1:0] load_result_c;
    logic [SHW-1:0]  shamt_c;

    alu_decode u_decode (
        .aluop     (Aluop),
        .funct7    (funct7),
        .funct3    (funct3),
        .op_c      (dec_op),
        .illegal_c (dec_illegal)
    );

    // Single-cycle datapath; illegal decodes produce zero.
    always_comb begin
        shamt_c      = src_b[SHW-1:0];
        alu_result_c = '0;
        case (dec_op)
            OP_ADD:  alu_result_c = src_a + src_b;
            OP_SUB:  alu_result_c = src_a - src_b;
            OP_AND:  alu_result_c = src_a & src_b;
            OP_OR:   alu_result_c = src_a | src_b;
            OP_XOR:  alu_result_c = src_a ^ src_b;
            OP_SLT:  alu_result_c = XLEN'($signed(src_a) < $signed(src_b));
            OP_SLTU: alu_result_c = XLEN'(src_a < src_b);
            OP_SLL:  alu_result_c = src_a << shamt_c;
            OP_SRL:  alu_result_c = src_a >> shamt_c;
            OP_SRA:  alu_result_c = XLEN'($signed(src_a) >>> shamt_c);
            default: alu_result_c = '0;
        endcase
        if (dec_illegal) begin
            alu_result_c = '0;
        end
    end

`ifdef ALU_MUL_EN
    alu_state_t      state;
    alu_state_t      state_next;
    logic            start_mul_c;
    logic            mul_last_c;
    logic [XLEN-1:0] mul_cand;
    logic [XLEN-1:0] mul_plier;
    logic [XLEN-1:0] mul_acc;
    logic [XLEN-1:0] mul_sum_c;
    logic [SHW-1:0]  mul_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: flush aborts, MUL runs until the final step.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start_mul_c) state_next = ST_MUL;
                ST_MUL:  if (mul_last_c)  state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Handshake and output-register load selection.
    always_comb begin
        in_ready       = (state == ST_IDLE) && (!out_valid || out_ready) && !rst;
        accept_c       = in_valid && in_ready && !flush;
        start_mul_c    = accept_c && !dec_illegal && (dec_op == OP_MUL);
        mul_sum_c      = mul_acc + (mul_plier[0] ? mul_cand : '0);
        mul_last_c     = (state == ST_MUL) && (mul_cnt == SHW'(XLEN - 1));
        load_c         = (accept_c && !start_mul_c) || mul_last_c;
        load_result_c  = mul_last_c ? mul_sum_c : alu_result_c;
        load_illegal_c = mul_last_c ? 1'b0 : dec_illegal;
    end

    // Shift-add multiplier: one partial product per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_cand  <= '0;
            mul_plier <= '0;
            mul_acc   <= '0;
            mul_cnt   <= '0;
        end else if (start_mul_c) begin
            mul_cand  <= src_a;
            mul_plier <= src_b;
            mul_acc   <= '0;
            mul_cnt   <= '0;
        end else if ((state == ST_MUL) && !flush) begin
            mul_acc   <= mul_sum_c;
            mul_cand  <= mul_cand << 1;
            mul_plier <= mul_plier >> 1;
            mul_cnt   <= mul_cnt + SHW'(1);
        end
    end
`else
    // Handshake: readiness depends only on the output register.
    always_comb begin
        in_ready       = (!out_valid || out_ready) && !rst;
        accept_c       = in_valid && in_ready && !flush;
        load_c         = accept_c;
        load_result_c  = alu_result_c;
        load_illegal_c = dec_illegal;
    end
`endif

    // Output register: flush drops the result, new load wins over drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_zero    <= 1'b1;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_c) begin
            out_valid   <= 1'b1;
            out_result  <= load_result_c;
            out_zero    <= (load_result_c == '0);
            out_illegal <= load_illegal_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage (XLEN=32); MUL tests run when ALU_MUL_EN is defined.
module tb_alu_exec_stage;

    localparam int unsigned XLEN = 32;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      aluop = 2'b00;
    logic [6:0]      funct7 = 7'd0;
    logic [2:0]      funct3 = 3'd0;
    logic [XLEN-1:0] src_a = '0;
    logic [XLEN-1:0] src_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] out_result;
    logic            out_zero;
    logic            out_illegal;

    int errors = 0;
    int checks = 0;

    alu_exec_stage #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .Aluop       (aluop),
        .funct7      (funct7),
        .funct3      (funct3),
        .src_a       (src_a),
        .src_b       (src_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: instruction mnemonic from the encoding tables, then plain arithmetic.
    function automatic void model(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit ill, output bit is_mul);
        string m;
        logic [63:0] p;
        int sh;
        sh = int'(b % 32);
        m = "";
        if (op == 2'd0) m = "add";
        else if (op == 2'd1) m = "sub";
        else if (op == 2'd2) begin
            if (f7 == 7'h00) begin
                if (f3 == 3'd0) m = "add";
                else if (f3 == 3'd7) m = "and";
                else if (f3 == 3'd6) m = "or";
                else if (f3 == 3'd4) m = "xor";
                else if (f3 == 3'd2) m = "slt";
                else if (f3 == 3'd3) m = "sltu";
                else if (f3 == 3'd1) m = "sll";
                else if (f3 == 3'd5) m = "srl";
            end else if (f7 == 7'h20 && f3 == 3'd0) m = "sub";
            else if (f7 == 7'h20 && f3 == 3'd5) m = "sra";
            else if (f7 == 7'h01 && f3 == 3'd0 && MUL_EN) m = "mul";
        end else begin
            if (f3 == 3'd0) m = "add";
            else if (f3 == 3'd2) m = "slt";
            else if (f3 == 3'd3) m = "sltu";
            else if (f3 == 3'd4) m = "xor";
            else if (f3 == 3'd6) m = "or";
            else if (f3 == 3'd7) m = "and";
            else if (f3 == 3'd1 && f7 == 7'h00) m = "sll";
            else if (f3 == 3'd5 && f7 == 7'h00) m = "srl";
            else if (f3 == 3'd5 && f7 == 7'h20) m = "sra";
        end
        ill = (m == "");
        is_mul = (m == "mul");
        r = 32'd0;
        if (m == "add") r = a + b;
        else if (m == "sub") r = a - b;
        else if (m == "and") r = a & b;
        else if (m == "or") r = a | b;
        else if (m == "xor") r = a ^ b;
        else if (m == "slt") r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        else if (m == "sltu") r = (a < b) ? 32'd1 : 32'd0;
        else if (m == "sll") r = a << sh;
        else if (m == "srl") r = a >> sh;
        else if (m == "sra") r = a[31] ? ~((~a) >> sh) : (a >> sh);
        else if (m == "mul") begin
            p = {32'd0, a} * {32'd0, b};
            r = p[31:0];
        end
    endfunction

    // Present one op with out_ready=1, wait for acceptance, check the result at the expected latency.
    task automatic send(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        bit ei;
        bit em;
        int n;
        model(op, f7, f3, a, b, er, ei, em);
        aluop = op; funct7 = f7; funct3 = f3; src_a = a; src_b = b;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (em) begin
            for (int i = 0; i < int'(XLEN); i++) begin
                check("mul_busy", {in_ready, out_valid}, 0);
                @(posedge clk); #1;
            end
        end
        check("res_valid", out_valid, 1);
        check("res_value", out_result, er);
        check("res_zero", out_zero, (er == 32'd0));
        check("res_illegal", out_illegal, ei);
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Count cycles where out_valid rises unexpectedly.
    task automatic watch_quiet(input string tag, input int cycles);
        int stray;
        stray = 0;
        for (int i = 0; i < cycles; i++) begin
            if (out_valid) stray++;
            @(posedge clk); #1;
        end
        check(tag, stray, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rop;
        logic [6:0]  rf7;
        logic [2:0]  rf3;

        // Reset held two cycles.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_result", out_result, 0);
        check("rst_zero", out_zero, 1);
        check("rst_illegal", out_illegal, 0);
        check("rst_ready_in_reset", in_ready, 0);
        rst = 1'b0;
        #1;
        check("rst_ready_after", in_ready, 1);

        // Back-to-back R-type ops.
        send(2'b10, 7'h00, 3'b000, 32'd5, 32'd7);
        check("add_literal", out_result, 32'd12);
        send(2'b10, 7'h20, 3'b000, 32'd5, 32'd7);
        check("sub_literal", out_result, 32'hFFFF_FFFE);
        send(2'b10, 7'h20, 3'b101, 32'h8000_0000, 32'd4);
        check("sra_literal", out_result, 32'hF800_0000);
        send(2'b10, 7'h00, 3'b011, 32'd1, 32'hFFFF_FFFF);
        check("sltu_literal", out_result, 32'd1);
        send(2'b10, 7'h00, 3'b010, 32'd1, 32'hFFFF_FFFF);
        check("slt_literal", out_result, 32'd0);
        send(2'b00, 7'h7F, 3'b111, 32'hFFFF_FFFF, 32'd1);
        send(2'b01, 7'h01, 3'b101, 32'd3, 32'd3);
        send(2'b11, 7'h00, 3'b001, 32'h0000_0001, 32'd31);
        idle_cycle();

        // Backpressure: XOR result held three cycles.
        out_ready = 1'b0;
        aluop = 2'b10; funct7 = 7'h00; funct3 = 3'b100; src_a = 32'hF0; src_b = 32'hFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_result", out_result, 32'h0F);
            check("bp_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        aluop = 2'b00; src_a = 32'd1; src_b = 32'd2; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_valid", out_valid, 1);
        check("bp_next_result", out_result, 32'd3);

        // Illegal decode.
        send(2'b10, 7'h01, 3'b100, 32'd123, 32'd456);
        check("illegal_flag", out_illegal, 1);
        idle_cycle();

        // Flush of a held result with an op presented the same cycle.
        out_ready = 1'b0;
        aluop = 2'b00; src_a = 32'd9; src_b = 32'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        check("fl_held_valid", out_valid, 1);
        src_a = 32'd1; src_b = 32'd1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_ready", in_ready, 1);
        out_ready = 1'b1;
        watch_quiet("fl_no_accept", 3);

`ifdef ALU_MUL_EN
        // MUL latency and value.
        send(2'b10, 7'h01, 3'b000, 32'hFFFF_FFFF, 32'd3);
        check("mul_literal", out_result, 32'hFFFF_FFFD);
        idle_cycle();

        // Flush at cycle 10 of a MUL.
        aluop = 2'b10; funct7 = 7'h01; funct3 = 3'b000; src_a = 32'd6; src_b = 32'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("mulfl_valid", out_valid, 0);
        check("mulfl_ready", in_ready, 1);
        watch_quiet("mulfl_quiet", int'(XLEN) + 4);
        send(2'b10, 7'h01, 3'b000, 32'd6, 32'd7);
        check("mul_after_flush", out_result, 32'd42);
        idle_cycle();

        // Reset in the middle of a MUL.
        aluop = 2'b10; funct7 = 7'h01; funct3 = 3'b000; src_a = 32'hFFFF; src_b = 32'hFFFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mulrst_valid", out_valid, 0);
        check("mulrst_result", out_result, 0);
        check("mulrst_zero", out_zero, 1);
        rst = 1'b0;
        watch_quiet("mulrst_quiet", int'(XLEN) + 4);
`endif

        // Randomized ops with occasional idle gaps.
        for (int k = 0; k < 300; k++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: rf7 = 7'h00;
                1: rf7 = 7'h20;
                2: rf7 = 7'h01;
                default: rf7 = 7'($urandom);
            endcase
            rf3 = 3'($urandom);
            if ((k % 8) == 7) begin
                rop = 2'b10; rf7 = 7'h01; rf3 = 3'b000;
            end
            case ($urandom_range(0, 3))
                0: ra = 32'($urandom_range(0, 15));
                1: ra = 32'h8000_0000;
                2: ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            send(rop, rf7, rf3, ra, rb);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
